// File: rtl/ula_pkg.sv
// Shared constants, command encodings and FSM states for the ULA sequencing controller.
package ula_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ULA0 = 2'b01,
        OP_ULA1 = 2'b10,
        OP_NOP  = 2'b11
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/ula_regfile.sv
// NREGS x WIDTH register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module ula_regfile #(
    parameter int WIDTH = ula_pkg::WIDTH,
    parameter int NREGS = 4,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];

    always_comb begin
        rf_d = rf_q;
        if (we) rf_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Reads see pre-write contents, so operands never observe a same-edge write.
    assign rdata1 = rf_q[raddr1];
    assign rdata2 = rf_q[raddr2];

endmodule

// File: rtl/ula_ctrl.sv
// Sequencing controller for the 16-bit ULA: accepts LOAD/ULA/NOP commands, feeds operands,
// writes the result back. Optional zero flag enabled by defining ULA_CTRL_ZERO_EN.
module ula_ctrl
    import ula_pkg::*;
#(
    parameter int WIDTH = ula_pkg::WIDTH,
    parameter int NREGS = 4,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic             ula_op,
    input  logic [WIDTH-1:0] ula_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             zero
);

    state_e           state_q, state_d;
    logic             rdy_q;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] ula_a_q, ula_a_d;
    logic [WIDTH-1:0] ula_b_q, ula_b_d;
    logic             ula_op_q, ula_op_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata1, rdata2;

    ula_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (cmd_rs1),
        .raddr2 (cmd_rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // rdy_q keeps cmd_ready low through reset and rises on the first edge after release.
    assign cmd_ready = rdy_q && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        ula_a_d     = ula_a_q;
        ula_b_d     = ula_b_q;
        ula_op_d    = ula_op_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        we          = 1'b0;
        waddr       = rd_q;
        wdata       = ula_out;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op_e'(cmd_op))
                        OP_LOAD: begin
                            we    = 1'b1;
                            waddr = cmd_rd;
                            wdata = cmd_imm;
                        end
                        OP_ULA0, OP_ULA1: begin
                            ula_a_d  = rdata1;
                            ula_b_d  = rdata2;
                            ula_op_d = cmd_op[1];
                            rd_d     = cmd_rd;
                            state_d  = ST_EXEC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_EXEC: begin
                we      = 1'b1;
                waddr   = rd_q;
                wdata   = ula_out;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (we) begin
            res_valid_d = 1'b1;
            res_data_d  = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            rd_q        <= '0;
            ula_a_q     <= '0;
            ula_b_q     <= '0;
            ula_op_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            rd_q        <= rd_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_op_q    <= ula_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign ula_a     = ula_a_q;
    assign ula_b     = ula_b_q;
    assign ula_op    = ula_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

`ifdef ULA_CTRL_ZERO_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (we) zero_d = (wdata == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_q <= 1'b0;
        else        zero_q <= zero_d;
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Self-checking bench for ula_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a command-level model of the register file.
module tb_ula_ctrl;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b11;
    logic [1:0]   cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [W-1:0] cmd_imm = '0;
    logic [W-1:0] ula_a, ula_b, ula_out, res_data;
    logic         ula_op, res_valid, zero;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ula_ctrl #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_out(ula_out),
        .res_valid(res_valid), .res_data(res_data), .zero(zero)
    );

    // Attached ULA: op_select 0 adds, 1 subtracts.
    function automatic logic [W-1:0] ula_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        return op ? (a - b) : (a + b);
    endfunction

    assign ula_out = ula_f(ula_a, ula_b, ula_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Command-level model: one pending ULA op at most, results computed from ula_f.
    logic [W-1:0] m_rf [N] = '{default: '0};
    logic         m_alive = 1'b0, m_busy = 1'b0;
    logic [1:0]   m_rd = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_op = 1'b0, m_rv = 1'b0, m_zero = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_rf[i] = '0;
            m_alive = 0; m_busy = 0; m_rd = 0; m_a = 0; m_b = 0; m_op = 0;
            m_rv = 0; m_res = 0; m_zero = 0;
        end else begin
            m_rv = 0;
            if (m_busy) begin
                m_res = ula_f(m_a, m_b, m_op);
                m_rf[m_rd] = m_res;
                m_rv = 1;
                m_busy = 0;
`ifdef ULA_CTRL_ZERO_EN
                m_zero = (m_res == 0);
`endif
            end else if (m_alive && cmd_valid) begin
                if (cmd_op == 2'b00) begin
                    m_rf[cmd_rd] = cmd_imm;
                    m_res = cmd_imm;
                    m_rv = 1;
`ifdef ULA_CTRL_ZERO_EN
                    m_zero = (cmd_imm == 0);
`endif
                end else if (cmd_op != 2'b11) begin
                    m_a = m_rf[cmd_rs1];
                    m_b = m_rf[cmd_rs2];
                    m_op = cmd_op[1];
                    m_rd = cmd_rd;
                    m_busy = 1;
                end
            end
            m_alive = 1;
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_alive && !m_busy});
        chk("ula_a", {16'd0, ula_a}, {16'd0, m_a});
        chk("ula_b", {16'd0, ula_b}, {16'd0, m_b});
        chk("ula_op", {31'd0, ula_op}, {31'd0, m_op});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
        chk("res_data", {16'd0, res_data}, {16'd0, m_res});
        chk("zero", {31'd0, zero}, {31'd0, m_zero});
    end

    // Returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [W-1:0] imm);
        bit ok = 0;
        cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL send_timeout: cmd_ready stayed 0, expected 1");
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_res_data", {16'd0, res_data}, 32'd0);
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Reset in the middle of an EXEC cycle.
        send(2'b00, 2'd1, 2'd0, 2'd0, 16'h0005);
        send(2'b01, 2'd0, 2'd1, 2'd1, 16'h0);
        chk("exec_pre_rst_a", {16'd0, ula_a}, 32'h5);
        #1 rst_n = 0;
        #1;
        chk("midexec_ready", {31'd0, cmd_ready}, 32'd0);
        chk("midexec_a", {16'd0, ula_a}, 32'd0);
        chk("midexec_rv", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); #1;
        send(2'b01, 2'd2, 2'd0, 2'd1, 16'h0);
        chk("rst_readback_a", {16'd0, ula_a}, 32'd0);
        chk("rst_readback_b", {16'd0, ula_b}, 32'd0);
        @(posedge clk); #1;
        chk("rst_readback_rv", {31'd0, res_valid}, 32'd1);

        // Zero flag and back-to-back LOADs.
        send(2'b00, 2'd0, 2'd0, 2'd0, 16'h0000);
`ifdef ULA_CTRL_ZERO_EN
        chk("zero_set", {31'd0, zero}, 32'd1);
`else
        chk("zero_tied", {31'd0, zero}, 32'd0);
`endif
        send(2'b00, 2'd0, 2'd0, 2'd0, 16'h0001);
        chk("load0_rv", {31'd0, res_valid}, 32'd1);
        chk("load0_data", {16'd0, res_data}, 32'h1);
        chk("zero_clr", {31'd0, zero}, 32'd0);
        send(2'b00, 2'd1, 2'd0, 2'd0, 16'h0003);
        chk("load1_rv", {31'd0, res_valid}, 32'd1);
        chk("load1_data", {16'd0, res_data}, 32'h3);

        // SUB r2 = r0 - r1 = 0xFFFE.
        send(2'b10, 2'd2, 2'd0, 2'd1, 16'h0);
        chk("sub_a", {16'd0, ula_a}, 32'h1);
        chk("sub_b", {16'd0, ula_b}, 32'h3);
        chk("sub_op", {31'd0, ula_op}, 32'd1);
        chk("sub_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        chk("sub_rv", {31'd0, res_valid}, 32'd1);
        chk("sub_data", {16'd0, res_data}, 32'hFFFE);
        send(2'b01, 2'd1, 2'd2, 2'd0, 16'h0);
        chk("r2_readback", {16'd0, ula_a}, 32'hFFFE);
        @(posedge clk); #1;

        // r3 = r3 + r3 with 0xFFFF wraps to 0xFFFE.
        send(2'b00, 2'd3, 2'd0, 2'd0, 16'hFFFF);
        send(2'b01, 2'd3, 2'd3, 2'd3, 16'h0);
        chk("add_a", {16'd0, ula_a}, 32'hFFFF);
        chk("add_b", {16'd0, ula_b}, 32'hFFFF);
        chk("add_op", {31'd0, ula_op}, 32'd0);
        @(posedge clk); #1;
        chk("add_data", {16'd0, res_data}, 32'hFFFE);
        send(2'b01, 2'd0, 2'd3, 2'd3, 16'h0);
        chk("r3_overwrite", {16'd0, ula_a}, 32'hFFFE);
        @(posedge clk); #1;

        // Continuous valid with alternating LOAD / ULA ops.
        cmd_valid = 1;
        for (int i = 0; i < 80; i++) begin
            cmd_op  = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
            cmd_rd  = 2'($urandom_range(0, 3));
            cmd_rs1 = 2'($urandom_range(0, 3));
            cmd_rs2 = 2'($urandom_range(0, 3));
            cmd_imm = W'($urandom);
            @(posedge clk); #1;
        end

        // Fully random traffic, fields churn even while busy.
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_rd    = 2'($urandom_range(0, 3));
            cmd_rs1   = 2'($urandom_range(0, 3));
            cmd_rs2   = 2'($urandom_range(0, 3));
            cmd_imm   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Sequencing controller that drives the 16-bit ULA from the instruction side. It accepts one command at a time over a valid/ready handshake and reads operands from a small internal register file. It presents the operands and `op_select` to the combinational ULA, captures the ULA output, writes it back, and reports the result. It sits between the future instruction decoder and the existing `ula` instance, and owns the ULA's `in_a`/`in_b`/`op_select` inputs.

## Interface
- `WIDTH`, 16, datapath width; must match the ULA
- `NREGS`, 4, register-file depth (power of two, ≥2)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `cmd_valid` input 1: command present
- `cmd_ready` output 1: controller can accept a command
- `cmd_op` input 2: 00 = LOAD, 01 = ULA op with `op_select`=0, 10 = ULA op with `op_select`=1, 11 = NOP
- `cmd_rd` input log2(NREGS): destination register
- `cmd_rs1`, `cmd_rs2` input log2(NREGS) each: source registers
- `cmd_imm` input WIDTH: LOAD immediate
- `ula_a`, `ula_b` output WIDTH: registered operands to ULA `in_a`/`in_b`
- `ula_op` output 1: registered, to ULA `op_select`
- `ula_out` input WIDTH: ULA result (combinational from `ula_a`/`ula_b`/`ula_op`)
- `res_valid` output 1: one-cycle pulse, result written
- `res_data` output WIDTH: value written on the last write-back
- `zero` output 1: flag (see Configuration)

## Operation
- FSM states: IDLE, EXEC.
- IDLE: `cmd_ready`=1. A command is accepted on a rising edge with `cmd_valid`&&`cmd_ready`.
  - LOAD: `rf[rd]`<=`cmd_imm`, `res_data`<=`cmd_imm`, `res_valid`<=1. Stays in IDLE.
  - ULA op: `ula_a`<=`rf[rs1]`, `ula_b`<=`rf[rs2]`, `ula_op`<=`cmd_op[1]`. Goes to EXEC.
  - NOP: accepted with no effect; `res_valid` stays 0.
- EXEC: `cmd_ready`=0. Next edge: `rf[rd_latched]`<=`ula_out`, `res_data`<=`ula_out`, `res_valid`<=1. Goes to IDLE.
- `rd` is latched at accept. `cmd_*` may change freely during EXEC.
- rs1==rs2 and rd==rs are legal. Operands always come from pre-write values.
- `ula_a`/`ula_b`/`ula_op` hold their last values in IDLE and after LOAD.
- The result is a plain WIDTH-bit ULA output. There is no extension or truncation in this block.

## Timing
- Reset (async assert, sync deassert by the system):
  - `cmd_ready`=0 while `rst_n`=0, 1 on the first cycle after release.
  - `ula_a`=`ula_b`=0, `ula_op`=0, `res_valid`=0, `res_data`=0, `zero`=0, all `rf` entries 0, state IDLE.
- LOAD latency: 1 cycle. `res_valid` is high in the cycle after the accept edge. Back-to-back LOADs give one per cycle.
- ULA-op latency: 2 edges.
  - Operands appear the cycle after accept.
  - `ula_out` is sampled at the end of that cycle.
  - `res_valid` is high the following cycle.
  - Throughput: one op per 2 cycles.
- `res_valid` never stays high two cycles for the same command. It can be high in consecutive cycles for consecutive commands, including the cycle `cmd_ready` returns.
- Reset mid-EXEC aborts the op. There is no write-back, and the register file clears.

## Configuration
- `ULA_CTRL_ZERO_EN` defined: `zero` is registered with every write-back (LOAD or ULA op) as (written value == 0). Otherwise it holds its value.
- Not defined: `zero` is tied to 0 and no flag register is built.

## Structure
- Package `ula_pkg` holds:
  - `WIDTH` default constant
  - `cmd_op` encodings: `OP_LOAD`, `OP_ULA0`, `OP_ULA1`, `OP_NOP`
  - FSM state typedef: `ST_IDLE`, `ST_EXEC`
- Sub-module `ula_regfile`: NREGS×WIDTH, two async read ports, one sync write port, async active-low clear.
- The ULA itself is instantiated outside this block, in the bench or top level.

## Test plan
- Reset: assert `rst_n`=0 mid-EXEC → all outputs 0 immediately. After release, `cmd_ready`=1 and reading r0 via a ULA op yields operands 0x0000.
- LOAD r0=0x0001, r1=0x0003 back-to-back → `res_valid` on two consecutive cycles, `res_data`=0x0001 then 0x0003.
- ULA op, `cmd_op`=10, rs1=r0, rs2=r1, rd=r2 → EXEC cycle shows `ula_a`=0x0001, `ula_b`=0x0003, `ula_op`=1. Then `res_valid`=1 with `res_data` equal to the attached ULA's output, and r2 holds it.
- LOAD r3=0xFFFF, then `cmd_op`=01, rs1=rs2=r3, rd=r3 → operands 0xFFFF/0xFFFF, `ula_op`=0. r3 is overwritten with the ULA result.
- Hold `cmd_valid`=1 continuously with alternating ops → `cmd_ready`=0 in every EXEC cycle and no command is lost or duplicated.
- With `ULA_CTRL_ZERO_EN`: LOAD r0=0x0000 → `zero`=1; LOAD r0=0x0005 → `zero`=0. Without the macro, `zero` stays 0 throughout.
